ysyx_22040088_ifu_pf: RTL

Parametrised prefetching instruction fetch unit for the NPC pipeline. It issues fetch requests over a valid/ready memory port with variable response latency, predecodes JAL on return, and buffers instructions in an internal FIFO. It hands instructions to IDU over a valid/ready handshake. EXU redirects flush in-flight and buffered fetches exactly.

---
 rtl/ysyx_22040088_ifu_pkg.sv | 23 ++
 rtl/ysyx_22040088_ifu_pf_fifo.sv | 66 ++++++
 rtl/ysyx_22040088_ifu_pf.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22040088_ifu_pkg.sv
// Shared definitions for the prefetching IFU: JAL opcode, J-immediate
// extraction and the instruction buffer entry layout.
package ysyx_22040088_ifu_pkg;

    localparam logic [6:0]  OPC_JAL = 7'b1101111;
    localparam int unsigned PC_W    = 64;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic            jump;
    } ifu_entry_t;

    function automatic logic is_jal(input logic [31:0] inst);
        return inst[6:0] == OPC_JAL;
    endfunction

    // 21-bit byte offset of a JAL; the caller sign-extends to its PC width.
    function automatic logic [20:0] jal_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ysyx_22040088_ifu_pf_fifo.sv
// Synchronous FIFO with flush, used for both the pending-PC queue and the
// instruction buffer. Push and pop may coincide at any occupancy.
module ysyx_22040088_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned AW1 = AW + 1;
    localparam logic [AW:0] FULL_CNT = AW1'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    // A full FIFO still accepts a push when a pop frees the slot this cycle.
    assign w_pop   = pop & ~w_empty & ~flush;
    assign w_push  = push & (~w_full | w_pop) & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + AW1'(1);
                2'b01:   r_count <= r_count - AW1'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule

// File: rtl/ysyx_22040088_ifu_pf.sv
// Prefetching instruction fetch unit: credit-limited request issue, in-order
// response matching, JAL predecode/follow, and exact flush on EXU redirect.
module ysyx_22040088_ifu_pf
    import ysyx_22040088_ifu_pkg::*;
#(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [63:0]     imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            out_jump
);
    localparam int unsigned CW      = $clog2(DEPTH) + 1;
    localparam int unsigned CW1     = CW + 1;
    localparam int unsigned EW      = $bits(ifu_entry_t);
    localparam logic [CW:0] CREDITS = CW1'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_outstanding;
    logic [CW-1:0]   w_fifo_count;
    logic [CW:0]     w_credit_used;
    logic [XLEN-1:0] w_resp_pc;
    logic            w_req_fire;
    logic            w_dropping;
    logic            w_accept;
    logic [31:0]     w_inst;
    logic            w_jal;
    logic [20:0]     w_imm;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_redirect_pc;
    logic [CW-1:0]   w_out_nxt;
    logic [CW-1:0]   w_drop_nxt;
    logic [XLEN-1:0] w_fetch_nxt;
    ifu_entry_t      w_entry;
    logic [EW-1:0]   w_head_bits;
    ifu_entry_t      w_head;
    logic            w_out_fire;

    // Every outstanding request owns a buffer slot, so responses never stall.
    assign w_credit_used  = {1'b0, w_outstanding} + {1'b0, w_fifo_count};
    assign imem_req_valid = rst & ~redirect_valid & (w_credit_used < CREDITS);
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid & imem_req_ready;

    assign w_dropping    = (r_drop_cnt != '0);
    assign w_accept      = imem_resp_valid & ~w_dropping & ~redirect_valid;
    assign w_inst        = w_resp_pc[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
    assign w_jal         = w_accept & is_jal(w_inst);
    assign w_imm         = jal_imm(w_inst);
    assign w_target      = w_resp_pc + {{(XLEN-21){w_imm[20]}}, w_imm};
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    assign w_out_nxt = w_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

    // Every request still in flight after a redirect or taken JAL is younger
    // than the new path start, so all of them must be discarded.
    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_valid || w_jal) begin
            w_drop_nxt = w_out_nxt;
        end else if (imem_resp_valid && w_dropping) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end
    end

    always_comb begin
        w_fetch_nxt = r_fetch_pc;
        if (redirect_valid) begin
            w_fetch_nxt = w_redirect_pc;
        end else if (w_jal) begin
            w_fetch_nxt = w_target;
        end else if (w_req_fire) begin
            w_fetch_nxt = r_fetch_pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_fetch_pc <= w_fetch_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    always_comb begin
        w_entry      = '0;
        w_entry.pc   = PC_W'(w_resp_pc);
        w_entry.inst = w_inst;
        w_entry.jump = w_jal;
    end

    ysyx_22040088_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pending (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (w_req_fire),
        .push_data (r_fetch_pc),
        .pop       (imem_resp_valid),
        .pop_data  (w_resp_pc),
        .count     (w_outstanding)
    );

    ysyx_22040088_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_accept),
        .push_data (w_entry),
        .pop       (w_out_fire),
        .pop_data  (w_head_bits),
        .count     (w_fifo_count)
    );

    assign w_head     = w_head_bits;
    assign out_valid  = (w_fifo_count != '0);
    assign w_out_fire = out_valid & out_ready & ~redirect_valid;
    assign out_pc     = XLEN'(w_head.pc);
    assign out_inst   = w_head.inst;
    assign out_jump   = w_head.jump;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (w_credit_used <= CREDITS);
        end
    end

endmodule
